// File: rtl/color_sensor_ctrl_pkg.sv
// Shared types and sensor pin codes for the colour path.
package color_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_DIV,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } ch_t;

  typedef enum logic {
    MODE_MEAS,
    MODE_CAL
  } mode_t;

  localparam logic [1:0] FILT_R        = 2'b00;
  localparam logic [1:0] FILT_G        = 2'b11;
  localparam logic [1:0] FILT_B        = 2'b01;
  localparam logic [1:0] FREQ_SCALE_20 = 2'b10;

  function automatic logic [1:0] filt_code(input ch_t ch);
    case (ch)
      CH_G:    return FILT_G;
      CH_B:    return FILT_B;
      default: return FILT_R;
    endcase
  endfunction

endpackage

// File: rtl/color_sensor_ctrl_if.sv
// Host-side request/result bundle between the colour controller and the decision logic.
interface color_sensor_ctrl_if #(
  parameter int OUT_W = 10
);
  logic             start;
  logic             cal_req;
  logic             busy;
  logic             cal_done;
  logic             color_valid;
  logic [OUT_W-1:0] r;
  logic [OUT_W-1:0] g;
  logic [OUT_W-1:0] b;

  modport master (
    output start, cal_req,
    input  busy, cal_done, color_valid, r, g, b
  );

  modport slave (
    input  start, cal_req,
    output busy, cal_done, color_valid, r, g, b
  );
endinterface

// File: rtl/color_sensor_ctrl_div.sv
// Serial restoring divider: loads on i_start, one quotient bit per cycle, o_done pulses
// when o_quo is final. Saturation is left to the caller.
module color_div #(
  parameter int N_W = 26,
  parameter int D_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_num,
  input  logic [D_W-1:0] i_den,
  output logic           o_done,
  output logic [N_W-1:0] o_quo
);
  localparam int BC_W = $clog2(N_W + 1);

  logic [N_W-1:0]  r_quo;
  logic [D_W-1:0]  r_rem;
  logic [D_W-1:0]  r_den;
  logic [BC_W-1:0] r_bits;
  logic            r_done;
  logic [D_W:0]    w_shift;
  logic            w_fits;
  logic [D_W-1:0]  w_rem_next;

  always_comb begin
    w_shift    = {r_rem, r_quo[N_W-1]};
    w_fits     = (w_shift >= {1'b0, r_den});
    w_rem_next = w_fits ? D_W'(w_shift - {1'b0, r_den}) : w_shift[D_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_bits <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_num;
        r_rem  <= '0;
        r_den  <= i_den;
        r_bits <= BC_W'(N_W);
      end else if (r_bits != '0) begin
        r_rem  <= w_rem_next;
        r_quo  <= {r_quo[N_W-2:0], w_fits};
        r_bits <= r_bits - 1'b1;
        if (r_bits == BC_W'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo;
endmodule

// File: rtl/color_sensor_ctrl.sv
// TCS3200 colour controller: R/G/B gated edge counting, white calibration, normalised output.
// Optional COLOR_AUTO_RUN_EN: after a measurement, restart immediately instead of idling.
module color_sensor_ctrl
  import color_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int OUT_W         = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freq_in,
  output logic [1:0]   filter_select,
  output logic [1:0]   freq_scale,
  output logic         led,
  color_sensor_ctrl_if.slave host
);
  localparam int N_W     = CNT_W + OUT_W;
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           r_state, w_state_next;
  ch_t              r_ch, w_ch_next;
  mode_t            r_mode, w_mode_next;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_sync;
  logic             w_edge;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_ref_cur;
  logic [CNT_W-1:0] r_ref [3];
  logic [OUT_W-1:0] r_shd [3];
  logic [OUT_W-1:0] r_r, r_g, r_b;
  logic             r_cal_done, r_valid;

  logic             w_tmr_clr, w_cnt_clr, w_ref_ld, w_div_start;
  logic             w_shd_ld, w_publish, w_cal_set;
  logic [OUT_W-1:0] w_shd_val, w_q_sat;
  logic [N_W-1:0]   w_num, w_quo;
  logic             w_div_done;

  // r_sync[1:0] is the synchroniser; r_sync[2] holds the previous synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[1:0], freq_in};
  end

  always_comb begin
    w_edge     = r_sync[1] & ~r_sync[2];
    w_cnt_next = (w_edge && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
    w_ref_cur  = r_ref[r_ch];
    w_num      = (N_W'(w_cnt_next) << OUT_W) - N_W'(w_cnt_next);
    w_q_sat    = (|w_quo[N_W-1:OUT_W]) ? '1 : w_quo[OUT_W-1:0];
  end

  // The divider is loaded on the GATE->DIV edge so its last bit lands in the final DIV cycle.
  color_div #(
    .N_W (N_W),
    .D_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_ref_cur),
    .o_done  (w_div_done),
    .o_quo   (w_quo)
  );

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    w_mode_next  = r_mode;
    w_tmr_clr    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_ref_ld     = 1'b0;
    w_div_start  = 1'b0;
    w_shd_ld     = 1'b0;
    w_shd_val    = '0;
    w_publish    = 1'b0;
    w_cal_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (host.cal_req || host.start) begin
          w_mode_next  = host.cal_req ? MODE_CAL : MODE_MEAS;
          w_ch_next    = CH_R;
          w_state_next = ST_SETTLE;
          w_tmr_clr    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
          w_state_next = ST_GATE;
          w_tmr_clr    = 1'b1;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_GATE: begin
        if (r_tmr == TMR_W'(GATE_CYCLES - 1)) begin
          w_tmr_clr = 1'b1;
          if (r_mode == MODE_CAL) begin
            w_ref_ld     = 1'b1;
            w_state_next = ST_NEXT;
          end else begin
            w_div_start  = (w_ref_cur != '0);
            w_state_next = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (w_ref_cur == '0) begin
          w_shd_ld     = 1'b1;
          w_shd_val    = '1;
          w_state_next = ST_NEXT;
        end else if (w_div_done) begin
          w_shd_ld     = 1'b1;
          w_shd_val    = w_q_sat;
          w_state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (r_ch != CH_B) begin
          w_ch_next    = (r_ch == CH_R) ? CH_G : CH_B;
          w_state_next = ST_SETTLE;
          w_tmr_clr    = 1'b1;
        end else begin
          w_state_next = ST_DONE;
          w_publish    = (r_mode == MODE_MEAS);
          w_cal_set    = (r_mode == MODE_CAL);
        end
      end
      ST_DONE: begin
        w_ch_next = CH_R;
`ifdef COLOR_AUTO_RUN_EN
        if (r_mode == MODE_MEAS) begin
          w_state_next = ST_SETTLE;
          w_tmr_clr    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ch       <= CH_R;
      r_mode     <= MODE_MEAS;
      r_tmr      <= '0;
      r_cnt      <= '0;
      r_r        <= '0;
      r_g        <= '0;
      r_b        <= '0;
      r_cal_done <= 1'b0;
      r_valid    <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_ref[i] <= '0;
        r_shd[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
      r_mode  <= w_mode_next;
      r_tmr   <= w_tmr_clr ? '0 : r_tmr + 1'b1;
      if (w_cnt_clr)              r_cnt <= '0;
      else if (r_state == ST_GATE) r_cnt <= w_cnt_next;
      if (w_ref_ld) r_ref[r_ch] <= w_cnt_next;
      if (w_shd_ld) r_shd[r_ch] <= w_shd_val;
      if (w_publish) begin
        r_r <= r_shd[0];
        r_g <= r_shd[1];
        r_b <= r_shd[2];
      end
      if (w_cal_set) r_cal_done <= 1'b1;
      r_valid <= w_publish;
    end
  end

  assign filter_select    = filt_code(r_ch);
  assign freq_scale       = FREQ_SCALE_20;
  assign led              = 1'b1;
  assign host.busy        = (r_state != ST_IDLE);
  assign host.cal_done    = r_cal_done;
  assign host.color_valid = r_valid;
  assign host.r           = r_r;
  assign host.g           = r_g;
  assign host.b           = r_b;
endmodule

// File: tb/tb_color_sensor_ctrl.sv
// Self-checking bench for color_sensor_ctrl: filter-aware sensor model, vector table,
// randomised rounds against an arithmetic model, and reset/auto-run corner sequences.
module tb_color_sensor_ctrl;
  localparam int GATE   = 1000;
  localparam int SETTLE = 16;
  localparam int CNT_W  = 16;
  localparam int OUT_W  = 10;
  localparam int QMAX   = (1 << OUT_W) - 1;
  localparam int LIMIT  = 12000;

  logic       clk = 1'b0;
  logic       rst;
  logic       freq_in;
  logic [1:0] filter_select;
  logic [1:0] freq_scale;
  logic       led;

  color_sensor_ctrl_if #(.OUT_W(OUT_W)) host_if();

  color_sensor_ctrl #(
    .GATE_CYCLES   (GATE),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CNT_W),
    .OUT_W         (OUT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .freq_in       (freq_in),
    .filter_select (filter_select),
    .freq_scale    (freq_scale),
    .led           (led),
    .host          (host_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int per [3];

  typedef struct {
    int cr, cg, cb;
    int mr, mg, mb;
    int er, eg, eb;
  } vec_t;

  always #5 clk = ~clk;

  // Sensor model: output period (in clk cycles) follows the selected filter; 0 means dark.
  function automatic int cur_period();
    case (filter_select)
      2'b00:   return per[0];
      2'b11:   return per[1];
      2'b01:   return per[2];
      default: return 0;
    endcase
  endfunction

  initial begin
    int p;
    freq_in = 1'b0;
    #3;
    forever begin
      p = cur_period();
      if (p == 0) begin
        freq_in = 1'b0;
        #5;
      end else begin
        freq_in = 1'b1;
        #(5 * p);
        p = cur_period();
        freq_in = 1'b0;
        if (p != 0) #(5 * p);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int cnt_lo(input int p);
    return (p == 0) ? 0 : GATE / p;
  endfunction

  function automatic int cnt_hi(input int p);
    return (p == 0) ? 0 : (GATE + p - 1) / p;
  endfunction

  function automatic int qref(input int c, input int rf);
    int q;
    if (rf == 0) return QMAX;
    q = (c * QMAX) / rf;
    return (q > QMAX) ? QMAX : q;
  endfunction

  function automatic int meas_total(input int r0, input int r1, input int r2);
    int t;
    t = 3 * (SETTLE + GATE + 1) + 1;
    t += (r0 == 0) ? 1 : CNT_W + OUT_W + 1;
    t += (r1 == 0) ? 1 : CNT_W + OUT_W + 1;
    t += (r2 == 0) ? 1 : CNT_W + OUT_W + 1;
    return t;
  endfunction

  function automatic int cal_total();
    return 3 * (SETTLE + GATE + 1) + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, int'(host_if.busy), 0);
    chk({tag, "_filter"}, int'(filter_select), 0);
    chk({tag, "_scale"}, int'(freq_scale), 2);
    chk({tag, "_led"}, int'(led), 1);
    chk({tag, "_cal_done"}, int'(host_if.cal_done), 0);
    chk({tag, "_valid"}, int'(host_if.color_valid), 0);
    chk({tag, "_r"}, int'(host_if.r), 0);
    chk({tag, "_g"}, int'(host_if.g), 0);
    chk({tag, "_b"}, int'(host_if.b), 0);
    chk({tag, "_ref_r"}, int'(dut.r_ref[0]), 0);
    chk({tag, "_ref_g"}, int'(dut.r_ref[1]), 0);
    chk({tag, "_ref_b"}, int'(dut.r_ref[2]), 0);
  endtask

  task automatic set_periods(input int a, input int b, input int c);
    per[0] = a;
    per[1] = b;
    per[2] = c;
    repeat (30) @(negedge clk);
  endtask

  // Returns the cycle (1 = first cycle after the accepting edge) of DONE for cal,
  // or of the color_valid pulse for a measurement; -1 if the bound expires.
  task automatic do_op(input bit cal, output int n_evt);
    int  n;
    bit  hit;
    @(negedge clk);
    if (cal) host_if.cal_req = 1'b1;
    else     host_if.start   = 1'b1;
    @(posedge clk);
    #1;
    host_if.cal_req = 1'b0;
    host_if.start   = 1'b0;
    chk("busy_after_accept", int'(host_if.busy), 1);
    n   = 1;
    hit = 1'b0;
    while (!hit && n < LIMIT) begin
      if (cal ? !host_if.busy : host_if.color_valid) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!hit) begin
      chk("op_timeout", n, -1);
      n_evt = -1;
    end else begin
      n_evt = cal ? n - 1 : n;
    end
  endtask

  task automatic check_cal(input string tag, input int a, input int b, input int c);
    int n, r0, g0, b0;
    r0 = int'(host_if.r);
    g0 = int'(host_if.g);
    b0 = int'(host_if.b);
    do_op(1'b1, n);
    chk({tag, "_cal_cycles"}, n, cal_total());
    chk({tag, "_cal_done"}, int'(host_if.cal_done), 1);
    chk_rng({tag, "_ref_r"}, int'(dut.r_ref[0]), cnt_lo(a), cnt_hi(a));
    chk_rng({tag, "_ref_g"}, int'(dut.r_ref[1]), cnt_lo(b), cnt_hi(b));
    chk_rng({tag, "_ref_b"}, int'(dut.r_ref[2]), cnt_lo(c), cnt_hi(c));
    chk({tag, "_cal_rgb_kept"}, int'(host_if.r == r0 && host_if.g == g0 && host_if.b == b0), 1);
  endtask

`ifndef COLOR_AUTO_RUN_EN
  vec_t tbl [4];
`endif

  initial begin
    int n;
    host_if.start   = 1'b0;
    host_if.cal_req = 1'b0;
    per[0] = 0;
    per[1] = 0;
    per[2] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

`ifdef COLOR_AUTO_RUN_EN
    set_periods(10, 10, 10);
    check_cal("ar", 10, 10, 10);
    set_periods(20, 20, 20);
    do_op(1'b0, n);
    chk("ar_first_valid", n, meas_total(1, 1, 1));
    chk("ar_r", int'(host_if.r), 511);
    for (int k = 0; k < 2; k++) begin
      int m;
      m = 0;
      do begin
        @(posedge clk);
        #1;
        m++;
        if (m == 1) chk("ar_busy_held", int'(host_if.busy), 1);
      end while (!host_if.color_valid && m < LIMIT);
      chk("ar_spacing", m, meas_total(1, 1, 1));
      chk("ar_g", int'(host_if.g), 511);
    end
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_cleared("ar_rst");
    @(negedge clk);
    rst = 1'b0;
`else
    // Uncalibrated run: every ref is zero, so DIV is one cycle and outputs saturate.
    set_periods(10, 10, 10);
    fork
      do_op(1'b0, n);
      begin
        repeat (300) @(negedge clk);
        host_if.start   = 1'b1;
        host_if.cal_req = 1'b1;
        @(negedge clk);
        host_if.start   = 1'b0;
        host_if.cal_req = 1'b0;
      end
    join
    chk("nocal_valid_cycle", n, meas_total(0, 0, 0));
    chk("nocal_r", int'(host_if.r), QMAX);
    chk("nocal_g", int'(host_if.g), QMAX);
    chk("nocal_b", int'(host_if.b), QMAX);
    @(posedge clk);
    #1;
    chk("nocal_valid_one_cycle", int'(host_if.color_valid), 0);
    chk("nocal_busy_fall", int'(host_if.busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("nocal_no_queued_req", int'(host_if.busy), 0);
    chk("nocal_no_cal", int'(host_if.cal_done), 0);

    tbl[0] = '{10, 10, 10, 20, 20, 20, 511, 511, 511};
    tbl[1] = '{10, 10, 10,  5,  5,  5, 1023, 1023, 1023};
    tbl[2] = '{10, 20,  8, 20, 10,  8, 511, 1023, 1023};
    tbl[3] = '{ 4,  8, 10,  8, 10, 20, 511, 818, 511};
    for (int i = 0; i < 4; i++) begin
      set_periods(tbl[i].cr, tbl[i].cg, tbl[i].cb);
      check_cal($sformatf("v%0d", i), tbl[i].cr, tbl[i].cg, tbl[i].cb);
      set_periods(tbl[i].mr, tbl[i].mg, tbl[i].mb);
      do_op(1'b0, n);
      chk($sformatf("v%0d_valid_cycle", i), n, meas_total(1, 1, 1));
      chk($sformatf("v%0d_r", i), int'(host_if.r), tbl[i].er);
      chk($sformatf("v%0d_g", i), int'(host_if.g), tbl[i].eg);
      chk($sformatf("v%0d_b", i), int'(host_if.b), tbl[i].eb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_fall", i), int'(host_if.busy), 0);
    end

    for (int rnd = 0; rnd < 3; rnd++) begin
      int cp [3];
      int mp [3];
      int rlo, rhi, mlo, mhi, zr [3];
      int act [3];
      for (int c = 0; c < 3; c++) begin
        cp[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 20));
        mp[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 20));
        zr[c] = (cp[c] == 0) ? 0 : 1;
      end
      set_periods(cp[0], cp[1], cp[2]);
      check_cal($sformatf("rnd%0d", rnd), cp[0], cp[1], cp[2]);
      set_periods(mp[0], mp[1], mp[2]);
      do_op(1'b0, n);
      chk($sformatf("rnd%0d_valid_cycle", rnd), n, meas_total(zr[0], zr[1], zr[2]));
      act[0] = int'(host_if.r);
      act[1] = int'(host_if.g);
      act[2] = int'(host_if.b);
      for (int c = 0; c < 3; c++) begin
        rlo = cnt_lo(cp[c]);
        rhi = cnt_hi(cp[c]);
        mlo = cnt_lo(mp[c]);
        mhi = cnt_hi(mp[c]);
        chk_rng($sformatf("rnd%0d_ch%0d_p%0d_over_p%0d", rnd, c, mp[c], cp[c]), act[c],
                qref(mlo, rhi), qref(mhi, rlo));
      end
    end

    // Asynchronous reset in the middle of the green counting window.
    set_periods(10, 10, 10);
    check_cal("pre_rst", 10, 10, 10);
    @(negedge clk);
    host_if.start = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    n = 0;
    while (filter_select != 2'b11 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("green_phase_reached", int'(n < LIMIT), 1);
    repeat (SETTLE + 400) @(negedge clk);
    #3 rst = 1'b1;
    #1 check_cleared("mid_gate_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", int'(host_if.busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
